sdram_arbit: RTL
================

Name: sdram_arbit

Overview:
- Owns the single SDRAM command/address bus and shares it between four command sources: power-up init, auto-refresh, burst write and burst read.
- Holds the bus for the init sequencer until init_end.
- Then grants one of auto-refresh, write or read at a time, each granted source running until it reports its end.
- Sits between the init/aref/write/read sequencers and the SDRAM pins.

Parameters:
- CMD_NOP, 4'b0111, idle command {cs_n,ras_n,cas_n,we_n}
- ADDR_W, 13, SDRAM address width
- BA_W, 2, bank address width

Ports:
- init_clk  in  1  system clock, 100 MHz
- init_rst_n  in  1  asynchronous active-low reset
- init_end  in  1  init sequence finished (level, stays high)
- init_cmd  in  4  init command
- init_addr  in  ADDR_W  init address
- init_bank  in  BA_W  init bank
- aref_req  in  1  refresh request (level, held until granted)
- aref_end  in  1  one-cycle pulse, refresh sequence done
- aref_cmd / aref_addr / aref_bank  in  4 / ADDR_W / BA_W  refresh bus
- wr_req  in  1  write request (level)
- wr_end  in  1  one-cycle pulse, write burst done
- wr_cmd / wr_addr / wr_bank  in  4 / ADDR_W / BA_W  write bus
- rd_req  in  1  read request (level)
- rd_end  in  1  one-cycle pulse, read burst done
- rd_cmd / rd_addr / rd_bank  in  4 / ADDR_W / BA_W  read bus
- aref_en  out  1  refresh grant
- wr_en  out  1  write grant
- rd_en  out  1  read grant
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_ba  out  BA_W  bank pins
- sdram_addr  out  ADDR_W  address pins

Behaviour:
- Reset is init_clk / init_rst_n, asynchronous, active-low.
- States (registered): INIT, ARBIT, AREF, WRITE, READ. Reset state is INIT.
- Registered last_wr flag, reset 0: 1 after a completed write, 0 after a completed read. Used for the wr/rd tie-break.
- INIT: bus driven from init_*. INIT -> ARBIT on the cycle after init_end=1 is sampled.
- ARBIT decision, in this priority order:
  - aref_req -> AREF.
  - Else wr_req and rd_req both high -> READ if last_wr=1, else WRITE (alternation prevents starvation).
  - Else wr_req -> WRITE.
  - Else rd_req -> READ.
  - Else stay in ARBIT.
- AREF -> ARBIT on aref_end. WRITE -> ARBIT on wr_end. READ -> ARBIT on rd_end.
- A request changing while another grant is active has no effect; no preemption, including by aref_req.
- Every return passes through ARBIT for at least one NOP cycle, so back-to-back grants are separated by one idle cycle.
- Grants are combinational from the state register: aref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ). At most one grant is high at any time.
- If aref_end and wr_end arrive in the same cycle, only the end matching the current state is honoured; others are ignored.
- Bus mux is combinational on the state:
  - INIT -> init_*
  - AREF -> aref_*
  - WRITE -> wr_*
  - READ -> rd_*
  - ARBIT -> CMD_NOP, addr all ones, bank all ones
- {sdram_cs_n,sdram_ras_n,sdram_cas_n,sdram_we_n} = muxed cmd.
- sdram_cke = 1 at all times after reset.
- Reset values: state INIT, last_wr 0, all grants 0. Bus follows init_* (NOP/1fff/11 from the init block during its own reset).
- Reset mid-burst returns immediately to INIT; the grant drops asynchronously.
- Illegal state encodings go to INIT.

Test Plan:
- init_end low for 50 cycles, init_cmd=4'b0010 -> pins carry 0010, no grants; init_end=1 -> ARBIT next cycle, pins show 0111 / 1fff / 11.
- aref_req and wr_req rise together in ARBIT -> aref_en=1 next cycle, wr_en=0. aref_end pulse -> ARBIT for one NOP cycle, then wr_en=1.
- wr_req and rd_req held high continuously with end pulses 10 cycles after each grant -> grants alternate WRITE, READ, WRITE, READ; each separated by one ARBIT cycle.
- aref_req rises mid-write -> wr_en stays 1 until wr_end; aref_en asserts 2 cycles after wr_end.
- Only rd_req, rd_cmd=4'b0101, rd_addr=13'h0040 -> pins equal 0101 / 0040 while rd_en=1. Spurious wr_end during READ is ignored.
- init_rst_n pulsed low during WRITE -> wr_en=0 immediately; state INIT, last_wr=0; no grant until init_end is seen again.

Source files
------------

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: the init sequencer owns the bus until init_end, then
// auto-refresh, write and read are granted one at a time, each until its end pulse.
module sdram_arbit #(
    parameter logic [3:0]  CMD_NOP = 4'b0111,
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned BA_W    = 2
) (
    input  logic              init_clk,
    input  logic              init_rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [BA_W-1:0]   init_bank,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic [BA_W-1:0]   aref_bank,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_bank,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_bank,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr
);

    typedef enum logic [2:0] {
        StInit  = 3'd0,
        StArbit = 3'd1,
        StAref  = 3'd2,
        StWrite = 3'd3,
        StRead  = 3'd4
    } state_e;

    state_e            r_state;
    logic              r_last_wr;
    logic [3:0]        w_cmd;
    logic [ADDR_W-1:0] w_addr;
    logic [BA_W-1:0]   w_bank;

    always_ff @(posedge init_clk or negedge init_rst_n) begin
        if (!init_rst_n) begin
            r_state   <= StInit;
            r_last_wr <= 1'b0;
        end else begin
            case (r_state)
                StInit: begin
                    if (init_end) r_state <= StArbit;
                end
                StArbit: begin
                    // Refresh first; a wr/rd tie alternates on last_wr so neither starves.
                    if (aref_req)              r_state <= StAref;
                    else if (wr_req && rd_req) r_state <= r_last_wr ? StRead : StWrite;
                    else if (wr_req)           r_state <= StWrite;
                    else if (rd_req)           r_state <= StRead;
                end
                StAref: begin
                    if (aref_end) r_state <= StArbit;
                end
                StWrite: begin
                    if (wr_end) begin
                        r_state   <= StArbit;
                        r_last_wr <= 1'b1;
                    end
                end
                StRead: begin
                    if (rd_end) begin
                        r_state   <= StArbit;
                        r_last_wr <= 1'b0;
                    end
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign aref_en = (r_state == StAref);
    assign wr_en   = (r_state == StWrite);
    assign rd_en   = (r_state == StRead);

    always_comb begin
        w_cmd  = CMD_NOP;
        w_addr = '1;
        w_bank = '1;
        case (r_state)
            StInit: begin
                w_cmd  = init_cmd;
                w_addr = init_addr;
                w_bank = init_bank;
            end
            StAref: begin
                w_cmd  = aref_cmd;
                w_addr = aref_addr;
                w_bank = aref_bank;
            end
            StWrite: begin
                w_cmd  = wr_cmd;
                w_addr = wr_addr;
                w_bank = wr_bank;
            end
            StRead: begin
                w_cmd  = rd_cmd;
                w_addr = rd_addr;
                w_bank = rd_bank;
            end
            default: ;
        endcase
    end

    assign sdram_cke = 1'b1;
    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
    assign sdram_addr = w_addr;
    assign sdram_ba   = w_bank;

endmodule
